// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready comes straight from state, so downstream stalls never reach upstream combinationally.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != FULL) && !clear;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    count = 2'd0;
    case (state_q)
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // Flush drops validity only; the data registers keep whatever they held.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table followed by a
// randomised scoreboard run against a queue model of the stage contents.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        clear, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .clear     (clear),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected in that same cycle, before the edge.
  typedef struct {
    logic        clear;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        chk_state;
    logic        exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_count;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic c, input logic f, input logic iv, input logic [31:0] d,
                        input logic ordy, input logic chk, input logic er, input logic ev,
                        input logic [1:0] ec, input logic [31:0] ed);
    vec_t v;
    v.clear = c; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.chk_state = chk; v.exp_ready = er; v.exp_valid = ev; v.exp_count = ec; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic c, input logic f, input logic iv,
                               input logic [31:0] d, input logic ordy);
    clear     = c;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  int          exp_q[$];
  int unsigned next_in;
  logic        in_fire_s, out_fire_s;

  initial begin
    //          clr flu iv data          ordy chk rdy vld cnt data
    addVec(1, 0, 1, 32'hDEADBEEF, 0,   0,  0,  0,  0, 32'h0);
    addVec(1, 0, 1, 32'hDEADBEEF, 0,   1,  0,  0,  0, 32'h0);
    addVec(0, 0, 0, 32'h0,        1,   1,  1,  0,  0, 32'h0);
    // streaming
    addVec(0, 0, 1, 32'h1,        1,   1,  1,  0,  0, 32'h0);
    addVec(0, 0, 1, 32'h2,        1,   1,  1,  1,  1, 32'h1);
    addVec(0, 0, 1, 32'h3,        1,   1,  1,  1,  1, 32'h2);
    addVec(0, 0, 0, 32'h0,        1,   1,  1,  1,  1, 32'h3);
    addVec(0, 0, 0, 32'h0,        0,   1,  1,  0,  0, 32'h3);
    // skid / stall
    addVec(0, 0, 1, 32'hA,        0,   1,  1,  0,  0, 32'h3);
    addVec(0, 0, 1, 32'hB,        0,   1,  1,  1,  1, 32'hA);
    addVec(0, 0, 1, 32'hC,        0,   1,  0,  1,  2, 32'hA);
    addVec(0, 0, 1, 32'hC,        0,   1,  0,  1,  2, 32'hA);
    addVec(0, 0, 1, 32'hC,        0,   1,  0,  1,  2, 32'hA);
    addVec(0, 0, 1, 32'hC,        1,   1,  0,  1,  2, 32'hA);
    addVec(0, 0, 1, 32'hC,        1,   1,  1,  1,  1, 32'hB);
    addVec(0, 0, 0, 32'h0,        1,   1,  1,  1,  1, 32'hC);
    // flush from FULL, then flush discarding an input accepted in EMPTY
    addVec(0, 0, 1, 32'h10,       0,   1,  1,  0,  0, 32'hC);
    addVec(0, 0, 1, 32'h11,       0,   1,  1,  1,  1, 32'h10);
    addVec(0, 1, 1, 32'h12,       0,   1,  0,  1,  2, 32'h10);
    addVec(0, 1, 1, 32'h13,       0,   1,  1,  0,  0, 32'h10);
    addVec(0, 0, 0, 32'h0,        1,   1,  1,  0,  0, 32'h10);
    // clear and flush together in ONE
    addVec(0, 0, 1, 32'h55,       0,   1,  1,  0,  0, 32'h10);
    addVec(1, 1, 1, 32'h66,       1,   1,  0,  1,  1, 32'h55);
    addVec(0, 0, 0, 32'h0,        0,   1,  1,  0,  0, 32'h0);
    // clear while FULL
    addVec(0, 0, 1, 32'h70,       0,   1,  1,  0,  0, 32'h0);
    addVec(0, 0, 1, 32'h71,       0,   1,  1,  1,  1, 32'h70);
    addVec(1, 0, 1, 32'h72,       0,   1,  0,  1,  2, 32'h70);
    addVec(0, 0, 0, 32'h0,        0,   1,  1,  0,  0, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].clear, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data,
                    vecs[i].out_ready);
      #2;
      checkOutput($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
      if (vecs[i].chk_state) begin
        checkOutput($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
        checkOutput($sformatf("vec%0d count", i), {30'b0, count}, {30'b0, vecs[i].exp_count});
        checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      end
      @(posedge clk);
      #1;
    end

    // Randomised traffic against a queue model; payload is an incrementing counter.
    next_in = 32'h100;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      applyStimulus(1'b0, 1'b0, ($urandom_range(0, 3) != 0), next_in,
                    ($urandom_range(0, 3) != 0));
      #2;
      checkOutput("rand count", {30'b0, count}, exp_q.size());
      checkOutput("rand out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
      checkOutput("rand in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2)});
      in_fire_s  = in_valid && (exp_q.size() < 2);
      out_fire_s = out_ready && (exp_q.size() != 0);
      if (out_fire_s) checkOutput("rand order", out_data, exp_q[0]);
      @(posedge clk);
      #1;
      if (out_fire_s) void'(exp_q.pop_front());
      if (in_fire_s) begin
        exp_q.push_back(next_in);
        next_in++;
      end
    end

    // Drain and confirm nothing is left behind.
    for (int cyc = 0; cyc < 4; cyc++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      #2;
      if (out_valid && exp_q.size() != 0) checkOutput("drain order", out_data, exp_q[0]);
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    #2;
    checkOutput("drain empty", {31'b0, out_valid}, 32'h0);
    checkOutput("drain count", {30'b0, count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
